secded_decode_scheduler: RTL and testbench
==========================================

// Module: secded_decode_scheduler
// PURPOSE
//  Shares one combinational SECDED (8,4) decoder between two requesters.
//  - Round-robin arbitration between the requesters.
//  - Valid/ready handshake on the request side and on the response side.
//  - Holds the selected received word stable on the decoder input for a
//    programmable settle time, then registers the decoder result and tags it
//    with the requester ID.
//  - Keeps saturating counters of corrected single-bit errors and detected
//    double-bit errors, read out to LEDs/displays alongside the decoder.
// PARAMETERS
//  CNT_W    8  width of the error counters
//  DEC_LAT  1  extra settle cycles before capture; legal range 0..7
// PORTS
//  clk           in   1      system clock; all logic rising-edge
//  rst           in   1      synchronous reset, active-high
//  req0_valid    in   1      requester 0 has a word
//  req0_word     in   8      requester 0 received codeword
//  req0_ready    out  1      requester 0 word accepted this cycle
//  req1_valid    in   1      requester 1 has a word
//  req1_word     in   8      requester 1 received codeword
//  req1_ready    out  1      requester 1 word accepted this cycle
//  dec_word_o    out  8      codeword driven to the shared decoder
//  dec_data_i    in   4      decoder corrected data
//  dec_single_i  in   1      decoder: single error corrected
//  dec_double_i  in   1      decoder: double error detected
//  dec_pos_i     in   4      decoder: error bit position (1..8; 0 = none)
//  rsp_valid     out  1      response available
//  rsp_ready     in   1      consumer takes response
//  rsp_id        out  1      requester that owns the response
//  rsp_data      out  4      captured dec_data_i
//  rsp_sec       out  1      captured single-error flag
//  rsp_ded       out  1      captured double-error flag
//  rsp_pos       out  4      captured error position
//  clear_counts  in   1      synchronous clear of both counters
//  sec_count     out  CNT_W  saturating count of corrected words
//  ded_count     out  CNT_W  saturating count of uncorrectable words
//  busy          out  1      high in any state other than IDLE
// BEHAVIOUR
//  Reset: all outputs are 0, FSM = IDLE, last_grant = 1 (port 0 wins first).
//  FSM states: IDLE -> WAIT -> RESP -> IDLE.
//  - IDLE:
//    - Only valid port requesting: that port is granted.
//    - Both ports requesting: the port other than last_grant is granted.
//    - reqN_ready = grant (combinational, only in IDLE).
//    - On the handshake edge: latch the word into dec_word_o, latch
//      rsp_id and last_grant, go to WAIT.
//    - No port requesting: stay in IDLE; dec_word_o holds its last value.
//  - WAIT:
//    - Lasts exactly DEC_LAT+1 cycles; a 3-bit counter tracks it.
//    - On the final edge: register the dec_* inputs into the rsp_* outputs,
//      set rsp_valid = 1, go to RESP.
//  - RESP:
//    - rsp_* outputs are held stable while rsp_valid=1 and rsp_ready=0.
//    - On the edge where rsp_ready=1: rsp_valid drops to 0, go to IDLE.
//    - A new accept happens no earlier than the following cycle.
//  Latency: accept edge E0 -> rsp_valid high after edge E(DEC_LAT+1).
//    Minimum period is DEC_LAT+3 cycles per word.
//  Flags:
//  - dec_double_i has priority: rsp_ded = 1 and rsp_sec = 0, even if both
//    decoder flags are high.
//  - rsp_data is captured as-is even when rsp_ded = 1.
//  Counters:
//  - Update on the capture edge: sec_count +1 if rsp_sec, ded_count +1 if
//    rsp_ded.
//  - Both saturate at {CNT_W{1'b1}}.
//  - clear_counts wins over a simultaneous increment.
//  Reset in any state aborts the transaction; no partial response is issued.
//  Requester-side protocol: reqN_word is sampled only at the handshake edge.
// TESTING
//  1. Reset, req0_valid=1, word=8'h13, decoder stub no error, DEC_LAT=1 ->
//     req0_ready high 1 cycle; dec_word_o=8'h13; rsp_valid 2 edges later,
//     rsp_id=0, sec=ded=0.
//  2. req0 and req1 both valid continuously, rsp_ready=1 -> grants alternate
//     0,1,0,1; one response every 4 cycles.
//  3. Stub single=1, pos=3 -> rsp_sec=1, rsp_pos=3, sec_count 0->1;
//     stub double=1 (single also 1) -> rsp_ded=1, rsp_sec=0, ded_count +1.
//  4. rsp_ready=0 for 5 cycles during RESP -> rsp_* stable, both reqN_ready
//     stay 0; rsp_ready=1 -> back to IDLE next cycle.
//  5. CNT_W=2, 5 single errors -> sec_count saturates at 3; clear_counts
//     pulsed on a capture edge -> sec_count=0.
//  6. rst asserted during WAIT -> next cycle busy=0, rsp_valid=0, counters=0;
//     first grant after reset goes to req0.

Source files
------------

// File: rtl/secded_decode_scheduler_if.sv
// Bundle of request, decoder, response and counter signals for the shared
// SECDED (8,4) decode scheduler. The scheduler sits on the slave modport.
// The requesters, decoder and consumer sit on the master modport.
interface secded_decode_scheduler_if #(
    parameter int CNT_W = 8
);
    logic             req0_valid;
    logic [7:0]       req0_word;
    logic             req0_ready;
    logic             req1_valid;
    logic [7:0]       req1_word;
    logic             req1_ready;
    logic [7:0]       dec_word_o;
    logic [3:0]       dec_data_i;
    logic             dec_single_i;
    logic             dec_double_i;
    logic [3:0]       dec_pos_i;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [3:0]       rsp_data;
    logic             rsp_sec;
    logic             rsp_ded;
    logic [3:0]       rsp_pos;
    logic             clear_counts;
    logic [CNT_W-1:0] sec_count;
    logic [CNT_W-1:0] ded_count;
    logic             busy;

    modport slave (
        input  req0_valid, req0_word, req1_valid, req1_word,
        input  dec_data_i, dec_single_i, dec_double_i, dec_pos_i,
        input  rsp_ready, clear_counts,
        output req0_ready, req1_ready, dec_word_o,
        output rsp_valid, rsp_id, rsp_data, rsp_sec, rsp_ded, rsp_pos,
        output sec_count, ded_count, busy
    );

    modport master (
        output req0_valid, req0_word, req1_valid, req1_word,
        output dec_data_i, dec_single_i, dec_double_i, dec_pos_i,
        output rsp_ready, clear_counts,
        input  req0_ready, req1_ready, dec_word_o,
        input  rsp_valid, rsp_id, rsp_data, rsp_sec, rsp_ded, rsp_pos,
        input  sec_count, ded_count, busy
    );
endinterface

// File: rtl/secded_decode_scheduler.sv
// Shares one combinational SECDED (8,4) decoder between two requesters.
// Round-robin grant in IDLE. The word is held on the decoder for DEC_LAT+1
// cycles in WAIT. The result is registered and tagged with the owner.
// The response is held in RESP until the consumer takes it.
// Saturating counters track corrected and uncorrectable words.
module secded_decode_scheduler #(
    parameter int CNT_W   = 8,
    // Extra settle cycles before capture. Only values 0..7 fit the 3-bit wait counter.
    parameter int DEC_LAT = 1
) (
    input logic                      clk,
    input logic                      rst,
    secded_decode_scheduler_if.slave bus
);
    localparam logic [1:0]       ST_IDLE   = 2'd0;
    localparam logic [1:0]       ST_WAIT   = 2'd1;
    localparam logic [1:0]       ST_RESP   = 2'd2;
    localparam logic [2:0]       LAST_WAIT = 3'(DEC_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [1:0]       state_q, state_d;
    logic             lastGrant_q, lastGrant_d;
    logic [7:0]       decWord_q, decWord_d;
    logic [2:0]       waitCnt_q, waitCnt_d;
    logic             rspValid_q, rspValid_d;
    logic             rspId_q, rspId_d;
    logic [3:0]       rspData_q, rspData_d;
    logic             rspSec_q, rspSec_d;
    logic             rspDed_q, rspDed_d;
    logic [3:0]       rspPos_q, rspPos_d;
    logic [CNT_W-1:0] secCount_q, secCount_d;
    logic [CNT_W-1:0] dedCount_q, dedCount_d;
    logic             grant0, grant1;

    // Round-robin grant, only offered while idle; a contested grant goes to the port that did not win last
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == ST_IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = lastGrant_q;
                grant1 = !lastGrant_q;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    // Next-state logic for the accept / settle / respond sequence and the error counters
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        decWord_d   = decWord_q;
        waitCnt_d   = waitCnt_q;
        rspValid_d  = rspValid_q;
        rspId_d     = rspId_q;
        rspData_d   = rspData_q;
        rspSec_d    = rspSec_q;
        rspDed_d    = rspDed_q;
        rspPos_d    = rspPos_q;
        secCount_d  = secCount_q;
        dedCount_d  = dedCount_q;
        case (state_q)
            ST_IDLE: begin
                if (grant0 || grant1) begin
                    decWord_d   = grant1 ? bus.req1_word : bus.req0_word;
                    rspId_d     = grant1;
                    lastGrant_d = grant1;
                    waitCnt_d   = 3'd0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (waitCnt_q == LAST_WAIT) begin
                    rspData_d  = bus.dec_data_i;
                    rspDed_d   = bus.dec_double_i;
                    rspSec_d   = bus.dec_single_i && !bus.dec_double_i;
                    rspPos_d   = bus.dec_pos_i;
                    rspValid_d = 1'b1;
                    state_d    = ST_RESP;
                    if (bus.dec_single_i && !bus.dec_double_i && secCount_q != CNT_MAX) begin
                        secCount_d = secCount_q + 1'b1;
                    end
                    if (bus.dec_double_i && dedCount_q != CNT_MAX) begin
                        dedCount_d = dedCount_q + 1'b1;
                    end
                end else begin
                    waitCnt_d = waitCnt_q + 3'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rspValid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (bus.clear_counts) begin
            secCount_d = '0;
            dedCount_d = '0;
        end
    end

    // State registers; reset drops any transaction in flight and makes port 0 the first winner
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lastGrant_q <= 1'b1;
            decWord_q   <= 8'd0;
            waitCnt_q   <= 3'd0;
            rspValid_q  <= 1'b0;
            rspId_q     <= 1'b0;
            rspData_q   <= 4'd0;
            rspSec_q    <= 1'b0;
            rspDed_q    <= 1'b0;
            rspPos_q    <= 4'd0;
            secCount_q  <= '0;
            dedCount_q  <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            decWord_q   <= decWord_d;
            waitCnt_q   <= waitCnt_d;
            rspValid_q  <= rspValid_d;
            rspId_q     <= rspId_d;
            rspData_q   <= rspData_d;
            rspSec_q    <= rspSec_d;
            rspDed_q    <= rspDed_d;
            rspPos_q    <= rspPos_d;
            secCount_q  <= secCount_d;
            dedCount_q  <= dedCount_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.dec_word_o = decWord_q;
    assign bus.rsp_valid  = rspValid_q;
    assign bus.rsp_id     = rspId_q;
    assign bus.rsp_data   = rspData_q;
    assign bus.rsp_sec    = rspSec_q;
    assign bus.rsp_ded    = rspDed_q;
    assign bus.rsp_pos    = rspPos_q;
    assign bus.sec_count  = secCount_q;
    assign bus.ded_count  = dedCount_q;
    assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_secded_decode_scheduler.sv
// Self-checking bench for secded_decode_scheduler.
// A transaction-level model predicts every output on every cycle.
// Directed sequences pin the model with hand-computed literals.
// A long randomized run follows.
module tb_secded_decode_scheduler;
    localparam int CNT_W   = 2;
    localparam int DEC_LAT = 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    // Free-running 10-time-unit clock
    always #5 clk = ~clk;

    secded_decode_scheduler_if #(.CNT_W(CNT_W)) bus();

    secded_decode_scheduler #(.CNT_W(CNT_W), .DEC_LAT(DEC_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Decoder stub: flags and data are simple functions of the word so the model can predict them
    assign bus.dec_data_i   = bus.dec_word_o[7:4] ^ bus.dec_word_o[3:0];
    assign bus.dec_single_i = bus.dec_word_o[6];
    assign bus.dec_double_i = bus.dec_word_o[7];
    assign bus.dec_pos_i    = (bus.dec_word_o[7] | bus.dec_word_o[6]) ? bus.dec_word_o[3:0] : 4'd0;

    // Model state: one transaction in flight at most, described by its word, owner and capture time
    int         cyc;
    bit         mBusy, mValid, mLast, mId, mSec, mDed;
    int         mCapAt, mSecCnt, mDedCnt;
    logic [7:0] mWord;
    logic [3:0] mData, mPos;

    task automatic modelReset();
        mBusy = 0; mValid = 0; mLast = 1; mId = 0; mSec = 0; mDed = 0;
        mCapAt = 0; mSecCnt = 0; mDedCnt = 0; mWord = 8'd0; mData = 4'd0; mPos = 4'd0;
    endtask

    function automatic bit expGrant(input bit port);
        bit mine, other;
        mine  = port ? bus.req1_valid : bus.req0_valid;
        other = port ? bus.req0_valid : bus.req1_valid;
        return !mBusy && mine && (!other || (mLast != port));
    endfunction

    task automatic modelStep();
        bit g0, g1;
        cyc++;
        if (rst) begin
            modelReset();
        end else begin
            g0 = expGrant(1'b0);
            g1 = expGrant(1'b1);
            if (!mBusy) begin
                if (g0 || g1) begin
                    mBusy  = 1;
                    mId    = g1;
                    mLast  = g1;
                    mWord  = g1 ? bus.req1_word : bus.req0_word;
                    mCapAt = cyc + DEC_LAT + 1;
                end
            end else if (!mValid && cyc == mCapAt) begin
                mData  = mWord[7:4] ^ mWord[3:0];
                mDed   = mWord[7];
                mSec   = mWord[6] && !mWord[7];
                mPos   = (mWord[7] | mWord[6]) ? mWord[3:0] : 4'd0;
                mValid = 1;
                if (mSec && mSecCnt < CNT_MAX) mSecCnt++;
                if (mDed && mDedCnt < CNT_MAX) mDedCnt++;
            end else if (mValid && bus.rsp_ready) begin
                mValid = 0;
                mBusy  = 0;
            end
            if (bus.clear_counts) begin
                mSecCnt = 0;
                mDedCnt = 0;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic compareAll();
        if (!rst) begin
            checkOutput("req0_ready", 32'(bus.req0_ready), 32'(expGrant(1'b0)));
            checkOutput("req1_ready", 32'(bus.req1_ready), 32'(expGrant(1'b1)));
            checkOutput("busy", 32'(bus.busy), 32'(mBusy));
            checkOutput("dec_word_o", 32'(bus.dec_word_o), 32'(mWord));
            checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(mValid));
            checkOutput("sec_count", 32'(bus.sec_count), 32'(mSecCnt));
            checkOutput("ded_count", 32'(bus.ded_count), 32'(mDedCnt));
            if (mValid) begin
                checkOutput("rsp_id", 32'(bus.rsp_id), 32'(mId));
                checkOutput("rsp_data", 32'(bus.rsp_data), 32'(mData));
                checkOutput("rsp_sec", 32'(bus.rsp_sec), 32'(mSec));
                checkOutput("rsp_ded", 32'(bus.rsp_ded), 32'(mDed));
                checkOutput("rsp_pos", 32'(bus.rsp_pos), 32'(mPos));
            end
        end
    endtask

    // One clock: compare on the falling edge, advance the model on the rising edge
    task automatic tick();
        @(negedge clk);
        compareAll();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic applyStimulus(input bit v0, input logic [7:0] w0, input bit v1, input logic [7:0] w1,
                                 input bit rr, input bit clr, input bit r);
        bus.req0_valid   = v0;
        bus.req0_word    = w0;
        bus.req1_valid   = v1;
        bus.req1_word    = w1;
        bus.rsp_ready    = rr;
        bus.clear_counts = clr;
        rst              = r;
    endtask

    // Accept one word from a port and stop with the response pending; optionally clear on the capture edge
    task automatic runOne(input bit port, input logic [7:0] w, input bit clrAtCap);
        if (port) applyStimulus(0, 8'h00, 1, w, 0, 0, 0);
        else      applyStimulus(1, w, 0, 8'h00, 0, 0, 0);
        #1;
        checkOutput(port ? "lit_req1_ready" : "lit_req0_ready",
                    32'(port ? bus.req1_ready : bus.req0_ready), 32'd1);
        tick();
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 0);
        checkOutput("lit_dec_word", 32'(bus.dec_word_o), 32'(w));
        checkOutput("lit_busy_wait", 32'(bus.busy), 32'd1);
        for (int i = 0; i < DEC_LAT; i++) begin
            tick();
            checkOutput("lit_no_early_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        bus.clear_counts = clrAtCap;
        tick();
        bus.clear_counts = 1'b0;
        checkOutput("lit_rsp_latency", 32'(bus.rsp_valid), 32'd1);
        checkOutput("lit_rsp_id", 32'(bus.rsp_id), 32'(port));
    endtask

    task automatic releaseRsp();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        checkOutput("lit_idle_after_rsp", 32'(bus.busy), 32'd0);
    endtask

    // Directed sequences with literal expectations, then randomized traffic
    initial begin
        int         ids[$];
        logic [3:0] heldData;
        modelReset();
        cyc = 0;
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 1);
        tick();
        tick();
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 0);
        #1;
        checkOutput("lit_reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("lit_reset_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("lit_reset_word", 32'(bus.dec_word_o), 32'd0);
        checkOutput("lit_reset_sec", 32'(bus.sec_count), 32'd0);
        checkOutput("lit_reset_data", 32'(bus.rsp_data), 32'd0);

        // Clean word from port 0
        runOne(1'b0, 8'h13, 1'b0);
        checkOutput("lit_clean_data", 32'(bus.rsp_data), 32'h2);
        checkOutput("lit_clean_sec", 32'(bus.rsp_sec), 32'd0);
        checkOutput("lit_clean_ded", 32'(bus.rsp_ded), 32'd0);
        releaseRsp();

        // Both ports hammering with the consumer always ready: grants alternate, one response per 4 cycles
        applyStimulus(1, 8'h21, 1, 8'h12, 1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.rsp_valid) ids.push_back(int'(bus.rsp_id));
        end
        checkOutput("lit_rr_count", 32'(ids.size()), 32'd4);
        if (ids.size() == 4) begin
            checkOutput("lit_rr_id0", 32'(ids[0]), 32'd1);
            checkOutput("lit_rr_id1", 32'(ids[1]), 32'd0);
            checkOutput("lit_rr_id2", 32'(ids[2]), 32'd1);
            checkOutput("lit_rr_id3", 32'(ids[3]), 32'd0);
        end
        applyStimulus(0, 8'h00, 0, 8'h00, 1, 0, 0);
        while (bus.busy && cyc < 200) tick();
        bus.rsp_ready = 1'b0;

        // Single error at position 3, then double error with the single flag also set
        runOne(1'b0, 8'h43, 1'b0);
        checkOutput("lit_single_sec", 32'(bus.rsp_sec), 32'd1);
        checkOutput("lit_single_pos", 32'(bus.rsp_pos), 32'd3);
        checkOutput("lit_single_data", 32'(bus.rsp_data), 32'h7);
        checkOutput("lit_single_cnt", 32'(bus.sec_count), 32'd1);
        releaseRsp();
        runOne(1'b1, 8'hC5, 1'b0);
        checkOutput("lit_double_ded", 32'(bus.rsp_ded), 32'd1);
        checkOutput("lit_double_sec", 32'(bus.rsp_sec), 32'd0);
        checkOutput("lit_double_data", 32'(bus.rsp_data), 32'h9);
        checkOutput("lit_double_cnt", 32'(bus.ded_count), 32'd1);

        // Consumer stalls for 5 cycles while both ports request
        heldData = bus.rsp_data;
        applyStimulus(1, 8'h55, 1, 8'hAA, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("lit_stall_data", 32'(bus.rsp_data), 32'(heldData));
            checkOutput("lit_stall_ready", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
        end
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 0);
        releaseRsp();

        // Saturation of the 2-bit counter, then clear on a capture edge
        for (int i = 0; i < 5; i++) begin
            runOne(1'(i % 2), 8'h41 + 8'(i), 1'b0);
            releaseRsp();
        end
        checkOutput("lit_sec_saturated", 32'(bus.sec_count), 32'd3);
        runOne(1'b0, 8'h46, 1'b1);
        checkOutput("lit_clear_wins", 32'(bus.sec_count), 32'd0);
        releaseRsp();

        // Reset while waiting aborts everything and restores port 0 priority
        runOne(1'b1, 8'h42, 1'b0);
        releaseRsp();
        applyStimulus(0, 8'h00, 1, 8'h22, 0, 0, 0);
        tick();
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 1);
        tick();
        checkOutput("lit_abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("lit_abort_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("lit_abort_sec", 32'(bus.sec_count), 32'd0);
        applyStimulus(1, 8'h11, 1, 8'h22, 0, 0, 0);
        #1;
        checkOutput("lit_post_reset_r0", 32'(bus.req0_ready), 32'd1);
        checkOutput("lit_post_reset_r1", 32'(bus.req1_ready), 32'd0);

        // Randomized traffic checked every cycle against the model
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
                          ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 299) == 0));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
